// File: rtl/mux_con_frame_tx_pkg.sv
// Shared constants, state encoding and header-byte helper for the config-stream
// frame transmitter.
package mux_con_frame_tx_pkg;

    localparam logic [7:0] CON_SYNC          = 8'hA5;
    localparam int         CON_HDR_LEN       = 4;
    localparam int         REPLY_FLAG_BIT    = 0;
    localparam int         DEF_PAYLOAD_DEPTH = 64;
    localparam int         DEF_GAP_CYCLES    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Header layout: sync, type, length, flags (reply request in bit 0).
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx,
                                            input logic [7:0] typ,
                                            input logic [7:0] len,
                                            input logic       reply);
        logic [7:0] b;
        b = '0;
        case (idx)
            2'd0:    b = CON_SYNC;
            2'd1:    b = typ;
            2'd2:    b = len;
            default: b[REPLY_FLAG_BIT] = reply;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mux_con_frame_tx_if.sv
// Host command, config stream and reply stream signals of the frame transmitter.
interface mux_con_frame_tx_if;

    logic [7:0]  cmd_wr_data;
    logic        cmd_wr_en;
    logic        cmd_start;
    logic [7:0]  cmd_type;
    logic        cmd_reply_req;
    logic        busy;
    logic        cmd_err;
    logic [7:0]  con_dout;
    logic        con_dout_en;
    logic [7:0]  replay_din;
    logic        replay_din_en;
    logic [31:0] reply_word;
    logic [7:0]  reply_len;
    logic        reply_valid;

    modport master (
        output cmd_wr_data, cmd_wr_en, cmd_start, cmd_type, cmd_reply_req,
        output replay_din, replay_din_en,
        input  busy, cmd_err, con_dout, con_dout_en,
        input  reply_word, reply_len, reply_valid
    );

    modport slave (
        input  cmd_wr_data, cmd_wr_en, cmd_start, cmd_type, cmd_reply_req,
        input  replay_din, replay_din_en,
        output busy, cmd_err, con_dout, con_dout_en,
        output reply_word, reply_len, reply_valid
    );

endinterface

// File: rtl/mux_con_frame_tx_reply_cap.sv
// Reply stream capture: edge-detects the byte-valid strobe, keeps the first four
// bytes and a saturating byte count, and pulses valid when a reply ends.
module mux_con_frame_tx_reply_cap (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_din,
    input  logic        i_din_en,
    output logic [31:0] o_word,
    output logic [7:0]  o_len,
    output logic        o_valid
);

    logic        r_en_d;
    logic [7:0]  r_cnt;
    logic [31:0] r_word;
    logic [7:0]  r_len;
    logic        r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en_d  <= 1'b0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_en_d  <= i_din_en;
            r_valid <= 1'b0;
            if (i_din_en && !r_en_d) begin
                // First byte of a new reply also lands in the top slot.
                r_word <= {i_din, 24'h0};
                r_cnt  <= 8'd1;
            end else if (i_din_en) begin
                if (r_cnt < 8'd4) begin
                    case (r_cnt[1:0])
                        2'd0:    r_word[31:24] <= i_din;
                        2'd1:    r_word[23:16] <= i_din;
                        2'd2:    r_word[15:8]  <= i_din;
                        default: r_word[7:0]   <= i_din;
                    endcase
                end
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            end
            if (!i_din_en && r_en_d) begin
                r_len   <= r_cnt;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_word  = r_word;
    assign o_len   = r_len;
    assign o_valid = r_valid;

endmodule

// File: rtl/mux_con_frame_tx.sv
// Config-stream frame transmitter: payload buffer, header/payload framing with an
// enforced inter-frame gap, plus the reply capture sub-block.
//
// state | meaning
// IDLE  | accepting payload writes and start
// HDR   | sending the 4 header bytes
// PAY   | sending buffered payload bytes
// GAP   | mandatory idle cycles before the next frame
module mux_con_frame_tx
    import mux_con_frame_tx_pkg::*;
#(
    parameter int PAYLOAD_DEPTH = DEF_PAYLOAD_DEPTH,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mux_con_frame_tx_if.slave    bus
);

    localparam int CW = $clog2(PAYLOAD_DEPTH + 1);
    localparam int PW = $clog2(PAYLOAD_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    tx_state_e     r_state, w_state_nxt;
    logic [7:0]    r_buf [PAYLOAD_DEPTH];
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_len;
    logic [7:0]    r_type;
    logic          r_reply;
    logic [1:0]    r_hdr_idx;
    logic [GW-1:0] r_gap_cnt;
    logic          r_err;

    logic          w_idle, w_wr_ok, w_start_ok, w_drop;
    logic          w_hdr_last, w_pay_last, w_frame_end;
    logic [7:0]    w_dout;
    logic          w_dout_en;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_ok     = bus.cmd_wr_en && w_idle && (r_cnt < CW'(PAYLOAD_DEPTH));
    assign w_start_ok  = bus.cmd_start && w_idle;
    assign w_drop      = (bus.cmd_wr_en && !w_wr_ok) || (bus.cmd_start && !w_idle);
    assign w_hdr_last  = (r_state == ST_HDR) && (r_hdr_idx == 2'(CON_HDR_LEN - 1));
    assign w_pay_last  = (r_state == ST_PAY) && (8'(r_rd_ptr) == r_len - 8'd1);
    assign w_frame_end = (w_hdr_last && (r_len == 8'd0)) || w_pay_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Stream outputs decode straight from state so reset kills them immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_dout      = 8'h00;
        w_dout_en   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_HDR;
            ST_HDR: begin
                w_dout    = hdr_byte(r_hdr_idx, r_type, r_len, r_reply);
                w_dout_en = 1'b1;
                if (w_hdr_last) w_state_nxt = (r_len == 8'd0) ? ST_GAP : ST_PAY;
            end
            ST_PAY: begin
                w_dout    = r_buf[r_rd_ptr];
                w_dout_en = 1'b1;
                if (w_pay_last) w_state_nxt = ST_GAP;
            end
            ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_len     <= '0;
            r_type    <= '0;
            r_reply   <= 1'b0;
            r_hdr_idx <= '0;
            r_gap_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_wr_ok) r_cnt <= r_cnt + CW'(1);
            if (w_start_ok) begin
                r_len     <= 8'(r_cnt) + (w_wr_ok ? 8'd1 : 8'd0);
                r_type    <= bus.cmd_type;
                r_reply   <= bus.cmd_reply_req;
                r_hdr_idx <= '0;
                r_rd_ptr  <= '0;
            end
            if (r_state == ST_HDR) r_hdr_idx <= r_hdr_idx + 2'd1;
            if (r_state == ST_PAY) r_rd_ptr  <= r_rd_ptr + PW'(1);
            if (w_frame_end) begin
                r_cnt     <= '0;
                r_gap_cnt <= GW'(GAP_CYCLES - 1);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_buf[r_cnt[PW-1:0]] <= bus.cmd_wr_data;
    end

    assign bus.busy        = !w_idle;
    assign bus.cmd_err     = r_err;
    assign bus.con_dout    = w_dout;
    assign bus.con_dout_en = w_dout_en;

    mux_con_frame_tx_reply_cap u_reply_cap (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_din    (bus.replay_din),
        .i_din_en (bus.replay_din_en),
        .o_word   (bus.reply_word),
        .o_len    (bus.reply_len),
        .o_valid  (bus.reply_valid)
    );

endmodule

// File: tb/tb_mux_con_frame_tx.sv
// Scoreboard bench for mux_con_frame_tx: directed stimulus pushes expected stream
// bytes and replies; a negedge monitor pops and compares.
module tb_mux_con_frame_tx;

    localparam int GAP   = 16;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_con_frame_tx_if bus ();

    mux_con_frame_tx #(.PAYLOAD_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;
    int err_seen = 0;

    logic [7:0]  sbq [$];
    logic [39:0] rq  [$];
    logic [7:0]  m_buf [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: stream bytes, idle-zero, gap length, error pulses, replies.
    int         idle_run   = 0;
    bit         have_frame = 0;
    bit         prev_en    = 0;
    always @(negedge clk) begin
        if (rst) begin
            idle_run   = 0;
            have_frame = 0;
            prev_en    = 0;
        end else begin
            if (bus.con_dout_en) begin
                if (!prev_en && have_frame) chk("gap_min", (idle_run >= GAP) ? 1 : 0, 1);
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL con_dout_unexpected: got %0h expected none", bus.con_dout);
                end else begin
                    logic [7:0] e;
                    e = sbq.pop_front();
                    if (bus.con_dout !== e) begin
                        n_fail++;
                        $display("FAIL con_dout: got %0h expected %0h", bus.con_dout, e);
                    end
                end
                have_frame = 1;
                idle_run   = 0;
            end else begin
                chk("dout_idle_zero", bus.con_dout, 0);
                idle_run++;
            end
            prev_en = bus.con_dout_en;
            if (bus.cmd_err) err_seen++;
            if (bus.reply_valid) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL reply_unexpected: got %0h/%0d expected none", bus.reply_word, bus.reply_len);
                end else begin
                    logic [39:0] r;
                    r = rq.pop_front();
                    chk("reply_word", bus.reply_word, r[39:8]);
                    chk("reply_len", 32'(bus.reply_len), 32'(r[7:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] typ, input logic rr);
        sbq.push_back(8'hA5);
        sbq.push_back(typ);
        sbq.push_back(8'(m_buf.size()));
        sbq.push_back({7'b0, rr});
        foreach (m_buf[i]) sbq.push_back(m_buf[i]);
        m_buf.delete();
    endtask

    task automatic write(input logic [7:0] d, input bit drop);
        if (drop) exp_err++;
        else      m_buf.push_back(d);
        bus.cmd_wr_data = d;
        bus.cmd_wr_en   = 1'b1;
        tick();
        bus.cmd_wr_en   = 1'b0;
    endtask

    task automatic start(input logic [7:0] typ, input logic rr, input bit drop);
        if (drop) exp_err++;
        else      push_frame(typ, rr);
        bus.cmd_type      = typ;
        bus.cmd_reply_req = rr;
        bus.cmd_start     = 1'b1;
        tick();
        bus.cmd_start     = 1'b0;
    endtask

    task automatic wr_start(input logic [7:0] d, input logic [7:0] typ, input logic rr);
        m_buf.push_back(d);
        push_frame(typ, rr);
        bus.cmd_wr_data   = d;
        bus.cmd_wr_en     = 1'b1;
        bus.cmd_type      = typ;
        bus.cmd_reply_req = rr;
        bus.cmd_start     = 1'b1;
        tick();
        bus.cmd_wr_en     = 1'b0;
        bus.cmd_start     = 1'b0;
    endtask

    task automatic wait_idle(input int exp_cycles);
        int n;
        n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        chk("busy_bound", 32'(bus.busy), 0);
        if (exp_cycles >= 0) chk("busy_cycles", n, exp_cycles);
    endtask

    task automatic send_reply(input logic [63:0] bytes, input int n,
                              input logic [31:0] exp_word, input logic [7:0] exp_len);
        rq.push_back({exp_word, exp_len});
        for (int i = 0; i < n; i++) begin
            bus.replay_din    = bytes[63 - 8*i -: 8];
            bus.replay_din_en = 1'b1;
            tick();
        end
        bus.replay_din_en = 1'b0;
        bus.replay_din    = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_wr_data   = 8'h00;
        bus.cmd_wr_en     = 1'b0;
        bus.cmd_start     = 1'b0;
        bus.cmd_type      = 8'h00;
        bus.cmd_reply_req = 1'b0;
        bus.replay_din    = 8'h00;
        bus.replay_din_en = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_en", 32'(bus.con_dout_en), 0);
        chk("rst_dout", 32'(bus.con_dout), 0);
        chk("rst_err", 32'(bus.cmd_err), 0);
        chk("rst_rvalid", 32'(bus.reply_valid), 0);
        chk("rst_rword", bus.reply_word, 0);
        chk("rst_rlen", 32'(bus.reply_len), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: basic frame with reply request, exact latency and busy length
        write(8'h11, 0);
        write(8'h22, 0);
        write(8'h33, 0);
        chk("t1_busy_pre", 32'(bus.busy), 0);
        start(8'h07, 1'b1, 0);
        chk("t1_en_lat", 32'(bus.con_dout_en), 1);
        chk("t1_busy_rise", 32'(bus.busy), 1);
        wait_idle(7 + GAP);

        // 2: empty payload
        start(8'h3C, 1'b0, 0);
        wait_idle(4 + GAP);

        // 3: overfill buffer
        for (int i = 0; i < 65; i++) write(8'(i + 8'h80), (i == 64));
        start(8'h12, 1'b0, 0);
        wait_idle(4 + DEPTH + GAP);

        // 4: drops during frame and gap
        write(8'hA1, 0);
        write(8'hA2, 0);
        start(8'h44, 1'b0, 0);
        tick();
        write(8'hEE, 1);
        start(8'h55, 1'b1, 1);
        repeat (5) tick();
        write(8'hEF, 1);
        start(8'h56, 1'b1, 1);
        wait_idle(-1);
        chk("t4_en_idle", 32'(bus.con_dout_en), 0);
        write(8'h5A, 0);
        start(8'h46, 1'b1, 0);
        wait_idle(5 + GAP);

        // 5: replies overlapping a frame
        write(8'h3C, 0);
        start(8'h0A, 1'b1, 0);
        send_reply(64'hDEADBEEF01000000, 5, 32'hDEADBEEF, 8'd5);
        send_reply(64'hABCD000000000000, 2, 32'hABCD0000, 8'd2);
        wait_idle(-1);

        // 7: write and start in the same cycle
        write(8'h10, 0);
        write(8'h20, 0);
        wr_start(8'h30, 8'h09, 1'b0);
        wait_idle(7 + GAP);

        // 6: reset during second payload byte
        write(8'hC1, 0);
        write(8'hC2, 0);
        write(8'hC3, 0);
        write(8'hC4, 0);
        start(8'h0B, 1'b0, 0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("t6_en_abort", 32'(bus.con_dout_en), 0);
        chk("t6_busy_abort", 32'(bus.busy), 0);
        chk("t6_dout_abort", 32'(bus.con_dout), 0);
        chk("t6_bytes_left", sbq.size(), 3);
        sbq.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        write(8'h77, 0);
        start(8'h08, 1'b0, 0);
        wait_idle(5 + GAP);

        repeat (4) tick();
        chk("err_count", err_seen, exp_err);
        chk("frame_q_empty", sbq.size(), 0);
        chk("reply_q_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
